spi_master: RTL and testbench
=============================

SPI_MASTER -- requirements
Module: spi_master

Interface
REQ-001 Parameter CLK_DIV, default 2, SCLK half-period in clk cycles; legal range 1..255.
REQ-002 clk  input  1  system clock; all state changes on rising edge.
REQ-003 reset  input  1  synchronous, active-low reset; sampled on rising clk.
REQ-004 start  input  1  transfer request; sampled only in IDLE.
REQ-005 masterDataToSend  input  8  byte to shift out on MOSI, MSB first.
REQ-006 masterDataReceived  output  8  last complete byte captured from MISO.
REQ-007 busy  output  1  high from the cycle after start acceptance until return to IDLE.
REQ-008 done  output  1  one-cycle pulse on transfer completion.
REQ-009 SCLK  output  1  serial clock to slave; idles low (CPOL=0).
REQ-010 CS  output  1  active-low chip select; idles high.
REQ-011 MOSI  output  1  serial data to slave.
REQ-012 MISO  input  1  serial data from slave.

Function
REQ-013 The protocol SHALL be SPI mode 0: MOSI/MISO change while SCLK low; both ends sample on SCLK rising edge; 8 bits, MSB first.
REQ-014 The FSM SHALL have states IDLE, SETUP, TRANSFER, HOLD.
REQ-015 IDLE: start=1 SHALL latch masterDataToSend into tx shift register, clear bit counter, enter SETUP; start=0 stays IDLE.
REQ-016 SETUP: CS=0, SCLK=0, MOSI=tx bit 7, held CLK_DIV cycles, then enter TRANSFER.
REQ-017 TRANSFER: SCLK SHALL toggle every CLK_DIV cycles, yielding exactly 8 rising and 8 falling edges.
REQ-018 On the clk edge that drives SCLK 0->1, MISO SHALL be shifted into the rx shift register LSB and the bit counter incremented.
REQ-019 On the clk edge that drives SCLK 1->0, tx register SHALL shift left and MOSI take the new bit 7; after the 8th falling edge, enter HOLD.
REQ-020 HOLD: SCLK=0, CS=0, held CLK_DIV cycles; then CS=1, masterDataReceived <= rx register, done=1 for one cycle, enter IDLE.
REQ-021 done SHALL assert exactly 18*CLK_DIV+1 clk cycles after the start-accepting edge (37 for CLK_DIV=2).
REQ-022 start while busy SHALL be ignored; no queuing.
REQ-023 start held high continuously SHALL produce back-to-back transfers with CS high for exactly one clk cycle between them (the IDLE cycle carrying done).
REQ-024 Changes on masterDataToSend after acceptance SHALL not affect the current transfer.
REQ-025 masterDataReceived SHALL change only on the done cycle; otherwise holds its value.
REQ-026 MOSI in IDLE SHALL be 0.
REQ-027 CLK_DIV divider SHALL be an internal counter reset on every state entry.

Reset
REQ-028 reset=0 at a rising clk SHALL force: state IDLE, CS=1, SCLK=0, MOSI=0, busy=0, done=0, masterDataReceived=8'h00, shift registers and counters 0.
REQ-029 reset=0 mid-transfer SHALL abort it on the next clk edge: CS=1 and SCLK=0 immediately, no done pulse, masterDataReceived unchanged from reset value.
REQ-030 Reset SHALL take priority over start in the same cycle.

Verification
REQ-031 Loopback MOSI->MISO, CLK_DIV=2, send 8'hB5 -> masterDataReceived=8'hB5, done at cycle 37 after start, exactly 8 SCLK rising edges while CS=0.
REQ-032 Slave model returning 8'hCA (mode 0), send 8'hB5 -> masterDataReceived=8'hCA, slave receives 8'hB5.
REQ-033 start pulsed again at cycle 10 of a transfer of 8'hF0 -> ignored; single done; received byte unchanged by second request.
REQ-034 reset=0 at cycle 20 of a transfer -> next cycle CS=1, SCLK=0, busy=0; no done; masterDataReceived=8'h00.
REQ-035 start held high, data 8'hF0 then 8'h0F, loopback -> two done pulses 37 cycles apart; CS high one cycle between; received 8'hF0 then 8'h0F.
REQ-036 CLK_DIV=1, send 8'hA5 loopback -> 8'hA5 received; done at cycle 19; SCLK period 2 clk cycles.

Source files
------------

// File: rtl/spi_master.sv
// SPI master, mode 0 (CPOL=0, CPHA=0), 8-bit transfers, MSB first.
// One transfer is SETUP (CS low, first bit on MOSI), 16 SCLK half-periods
// and HOLD (CS still low, SCLK low), each phase CLK_DIV clk cycles long.
//
// Handshake: start is a request sampled only while the FSM is idle; it is
// accepted on the rising clk edge where state is IDLE and start=1, and busy
// rises on that edge.  A request seen while busy is dropped, not queued.
// done is a one-cycle pulse in the IDLE cycle that follows HOLD, and
// masterDataReceived updates on that same edge only.
module spi_master #(
  parameter int CLK_DIV = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [7:0] masterDataToSend,
  output logic [7:0] masterDataReceived,
  output logic       busy,
  output logic       done,
  output logic       SCLK,
  output logic       CS,
  output logic       MOSI,
  input  logic       MISO
);

  localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    SETUP    = 2'd1,
    TRANSFER = 2'd2,
    HOLD     = 2'd3
  } state_t;

  state_t     state;
  logic [7:0] div_cnt;
  logic [3:0] bit_cnt;
  logic [7:0] tx_sr;
  logic [7:0] rx_sr;

  // Transfer FSM; every output is a register so SCLK/CS/MOSI are glitch-free.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state              <= IDLE;
      div_cnt            <= 8'd0;
      bit_cnt            <= 4'd0;
      tx_sr              <= 8'd0;
      rx_sr              <= 8'd0;
      masterDataReceived <= 8'd0;
      busy               <= 1'b0;
      done               <= 1'b0;
      SCLK               <= 1'b0;
      CS                 <= 1'b1;
      MOSI               <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          SCLK <= 1'b0;
          if (start) begin
            tx_sr   <= masterDataToSend;
            bit_cnt <= 4'd0;
            div_cnt <= 8'd0;
            busy    <= 1'b1;
            CS      <= 1'b0;
            MOSI    <= masterDataToSend[7];
            state   <= SETUP;
          end else begin
            CS   <= 1'b1;
            MOSI <= 1'b0;
          end
        end

        SETUP: begin
          if (div_cnt == DIV_LAST) begin
            div_cnt <= 8'd0;
            state   <= TRANSFER;
          end else begin
            div_cnt <= div_cnt + 8'd1;
          end
        end

        TRANSFER: begin
          if (div_cnt == DIV_LAST) begin
            div_cnt <= 8'd0;
            if (!SCLK) begin
              // Rising SCLK: the slave's bit has been stable for a half-period.
              SCLK    <= 1'b1;
              rx_sr   <= {rx_sr[6:0], MISO};
              bit_cnt <= bit_cnt + 4'd1;
            end else begin
              // Falling SCLK: present the next bit for the following rise.
              SCLK  <= 1'b0;
              tx_sr <= {tx_sr[6:0], 1'b0};
              MOSI  <= tx_sr[6];
              if (bit_cnt == 4'd8) begin
                state <= HOLD;
              end
            end
          end else begin
            div_cnt <= div_cnt + 8'd1;
          end
        end

        HOLD: begin
          if (div_cnt == DIV_LAST) begin
            div_cnt            <= 8'd0;
            CS                 <= 1'b1;
            MOSI               <= 1'b0;
            busy               <= 1'b0;
            done               <= 1'b1;
            masterDataReceived <= rx_sr;
            state              <= IDLE;
          end else begin
            div_cnt <= div_cnt + 8'd1;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_master.sv
// Bench for spi_master: a CLK_DIV=2 instance with a selectable loopback or
// mode-0 slave on MISO, and a CLK_DIV=1 instance wired in loopback.
module tb_spi_master;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset;
  logic       start, start2;
  logic [7:0] data, data2;

  logic [7:0] rx1, rx2;
  logic       busy1, done1, sclk1, cs1, mosi1, miso1;
  logic       busy2, done2, sclk2, cs2, mosi2;

  // Slave side for instance 1
  logic       loopback;
  logic [7:0] slave_load;
  logic [7:0] slave_sh;
  logic [7:0] slave_rx;
  int         rise1;

  assign miso1 = loopback ? mosi1 : slave_sh[7];

  spi_master #(.CLK_DIV(2)) dut (
    .clk(clk), .reset(reset), .start(start), .masterDataToSend(data),
    .masterDataReceived(rx1), .busy(busy1), .done(done1),
    .SCLK(sclk1), .CS(cs1), .MOSI(mosi1), .MISO(miso1)
  );

  spi_master #(.CLK_DIV(1)) dut2 (
    .clk(clk), .reset(reset), .start(start2), .masterDataToSend(data2),
    .masterDataReceived(rx2), .busy(busy2), .done(done2),
    .SCLK(sclk2), .CS(cs2), .MOSI(mosi2), .MISO(mosi2)
  );

  // Mode-0 slave: first bit ready when CS falls, sample on SCLK rise,
  // shift out on SCLK fall.
  always @(negedge cs1) begin
    slave_sh = slave_load;
    slave_rx = 8'h00;
  end
  always @(posedge sclk1) begin
    if (!cs1) slave_rx = {slave_rx[6:0], mosi1};
    if (!cs1) rise1++;
  end
  always @(negedge sclk1) begin
    if (!cs1) slave_sh = {slave_sh[6:0], 1'b0};
  end

  // ---------------- scoreboard ----------------
  logic [7:0] exp_q[$];
  logic [7:0] exp_v;
  int checks = 0;
  int failures = 0;

  // ---------------- tests ----------------
  task automatic test_reset();
    reset = 1'b0; start = 1'b1; start2 = 1'b1; data = 8'hFF; data2 = 8'hFF;
    repeat (3) @(negedge clk);
    checks++; if (cs1 !== 1'b1)    begin failures++; $display("FAIL reset_cs got=%b exp=1", cs1); end
    checks++; if (sclk1 !== 1'b0)  begin failures++; $display("FAIL reset_sclk got=%b exp=0", sclk1); end
    checks++; if (mosi1 !== 1'b0)  begin failures++; $display("FAIL reset_mosi got=%b exp=0", mosi1); end
    checks++; if (busy1 !== 1'b0)  begin failures++; $display("FAIL reset_busy got=%b exp=0", busy1); end
    checks++; if (done1 !== 1'b0)  begin failures++; $display("FAIL reset_done got=%b exp=0", done1); end
    checks++; if (rx1 !== 8'h00)   begin failures++; $display("FAIL reset_rx got=%h exp=00", rx1); end
    checks++; if (cs2 !== 1'b1 || sclk2 !== 1'b0 || busy2 !== 1'b0)
      begin failures++; $display("FAIL reset_dut2 cs=%b sclk=%b busy=%b exp cs=1 sclk=0 busy=0", cs2, sclk2, busy2); end
    start = 1'b0; start2 = 1'b0; reset = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_loopback();
    int n; bit got;
    loopback = 1'b1; rise1 = 0;
    @(negedge clk); data = 8'hB5; start = 1'b1; exp_q.push_back(8'hB5);
    @(posedge clk);
    n = 0; got = 0;
    while (n < 200 && !got) begin
      @(negedge clk); n++;
      if (n == 1) begin
        start = 1'b0; data = 8'h00;
        checks++; if (busy1 !== 1'b1 || cs1 !== 1'b0)
          begin failures++; $display("FAIL lb_busy_cs busy=%b cs=%b exp busy=1 cs=0", busy1, cs1); end
      end
      if (done1) got = 1;
    end
    checks++;
    if (!got) begin failures++; $display("FAIL lb_timeout got no done exp done"); end
    else begin
      checks++; if (n != 37) begin failures++; $display("FAIL lb_latency got=%0d exp=37", n); end
      exp_v = exp_q.pop_front();
      checks++; if (rx1 !== exp_v) begin failures++; $display("FAIL lb_data got=%h exp=%h", rx1, exp_v); end
      checks++; if (rise1 != 8) begin failures++; $display("FAIL lb_rises got=%0d exp=8", rise1); end
      @(negedge clk);
      checks++; if (done1 !== 1'b0) begin failures++; $display("FAIL lb_done_pulse got=%b exp=0", done1); end
      checks++; if (cs1 !== 1'b1 || mosi1 !== 1'b0 || busy1 !== 1'b0)
        begin failures++; $display("FAIL lb_idle cs=%b mosi=%b busy=%b exp 1 0 0", cs1, mosi1, busy1); end
    end
  endtask

  task automatic test_slave();
    int n; bit got;
    loopback = 1'b0; slave_load = 8'hCA;
    @(negedge clk); data = 8'hB5; start = 1'b1; exp_q.push_back(8'hCA);
    @(posedge clk);
    n = 0; got = 0;
    while (n < 200 && !got) begin
      @(negedge clk); n++;
      if (n == 1) start = 1'b0;
      if (done1) got = 1;
    end
    checks++;
    if (!got) begin failures++; $display("FAIL slave_timeout got no done exp done"); end
    else begin
      exp_v = exp_q.pop_front();
      checks++; if (rx1 !== exp_v) begin failures++; $display("FAIL slave_master_rx got=%h exp=%h", rx1, exp_v); end
      checks++; if (slave_rx !== 8'hB5) begin failures++; $display("FAIL slave_rx got=%h exp=b5", slave_rx); end
    end
    loopback = 1'b1;
  endtask

  task automatic test_ignore_start();
    int n; int dones; bit got;
    loopback = 1'b1;
    @(negedge clk); data = 8'hF0; start = 1'b1; exp_q.push_back(8'hF0);
    @(posedge clk);
    n = 0; got = 0;
    while (n < 200 && !got) begin
      @(negedge clk); n++;
      if (n == 1) begin start = 1'b0; data = 8'h55; end
      if (n == 10) begin start = 1'b1; data = 8'h3C; end
      if (n == 11) start = 1'b0;
      if (done1) got = 1;
    end
    checks++;
    if (!got) begin failures++; $display("FAIL ign_timeout got no done exp done"); end
    else begin
      exp_v = exp_q.pop_front();
      checks++; if (rx1 !== exp_v) begin failures++; $display("FAIL ign_data got=%h exp=%h", rx1, exp_v); end
      dones = 0;
      repeat (50) begin
        @(negedge clk);
        if (done1 || busy1) dones++;
      end
      checks++; if (dones != 0) begin failures++; $display("FAIL ign_queued got=%0d busy/done cycles exp=0", dones); end
      checks++; if (rx1 !== 8'hF0) begin failures++; $display("FAIL ign_hold got=%h exp=f0", rx1); end
    end
  endtask

  task automatic test_back_to_back();
    int n; int m; bit got;
    loopback = 1'b1;
    @(negedge clk); data = 8'hF0; start = 1'b1;
    exp_q.push_back(8'hF0); exp_q.push_back(8'h0F);
    @(posedge clk);
    n = 0; got = 0;
    while (n < 200 && !got) begin
      @(negedge clk); n++;
      if (n == 1) data = 8'h0F;
      if (n == 36) begin
        checks++; if (cs1 !== 1'b0) begin failures++; $display("FAIL b2b_cs_hold got=%b exp=0", cs1); end
      end
      if (done1) got = 1;
    end
    checks++;
    if (!got) begin failures++; start = 1'b0; $display("FAIL b2b_timeout1 got no done exp done"); end
    else begin
      exp_v = exp_q.pop_front();
      checks++; if (rx1 !== exp_v) begin failures++; $display("FAIL b2b_data1 got=%h exp=%h", rx1, exp_v); end
      checks++; if (cs1 !== 1'b1) begin failures++; $display("FAIL b2b_cs_gap got=%b exp=1", cs1); end
      m = 0; got = 0;
      while (m < 200 && !got) begin
        @(negedge clk); m++;
        if (m == 1) begin
          start = 1'b0;
          checks++; if (cs1 !== 1'b0) begin failures++; $display("FAIL b2b_cs_one_cycle got=%b exp=0", cs1); end
        end
        if (done1) got = 1;
      end
      checks++;
      if (!got) begin failures++; $display("FAIL b2b_timeout2 got no done exp done"); end
      else begin
        checks++; if (m != 37) begin failures++; $display("FAIL b2b_spacing got=%0d exp=37", m); end
        exp_v = exp_q.pop_front();
        checks++; if (rx1 !== exp_v) begin failures++; $display("FAIL b2b_data2 got=%h exp=%h", rx1, exp_v); end
      end
    end
  endtask

  task automatic test_clk_div1();
    int n; int nr; int r1; int r2; bit got; logic prev;
    @(negedge clk); data2 = 8'hA5; start2 = 1'b1; exp_q.push_back(8'hA5);
    @(posedge clk);
    n = 0; got = 0; nr = 0; r1 = 0; r2 = 0; prev = 1'b0;
    while (n < 100 && !got) begin
      @(negedge clk); n++;
      if (n == 1) start2 = 1'b0;
      if (sclk2 && !prev) begin
        nr++;
        if (nr == 1) r1 = n;
        if (nr == 2) r2 = n;
      end
      prev = sclk2;
      if (done2) got = 1;
    end
    checks++;
    if (!got) begin failures++; $display("FAIL div1_timeout got no done exp done"); end
    else begin
      checks++; if (n != 19) begin failures++; $display("FAIL div1_latency got=%0d exp=19", n); end
      exp_v = exp_q.pop_front();
      checks++; if (rx2 !== exp_v) begin failures++; $display("FAIL div1_data got=%h exp=%h", rx2, exp_v); end
      checks++; if (nr != 8) begin failures++; $display("FAIL div1_rises got=%0d exp=8", nr); end
      checks++; if (r2 - r1 != 2) begin failures++; $display("FAIL div1_period got=%0d exp=2", r2 - r1); end
    end
  endtask

  task automatic test_reset_abort();
    int n; int bad;
    loopback = 1'b1;
    @(negedge clk); data = 8'h96; start = 1'b1;
    @(posedge clk);
    n = 0;
    while (n < 20) begin
      @(negedge clk); n++;
      if (n == 1) start = 1'b0;
    end
    reset = 1'b0;
    @(negedge clk);
    checks++; if (cs1 !== 1'b1 || sclk1 !== 1'b0 || busy1 !== 1'b0)
      begin failures++; $display("FAIL abort_outputs cs=%b sclk=%b busy=%b exp 1 0 0", cs1, sclk1, busy1); end
    checks++; if (rx1 !== 8'h00) begin failures++; $display("FAIL abort_rx got=%h exp=00", rx1); end
    reset = 1'b1;
    bad = 0;
    repeat (60) begin
      @(negedge clk);
      if (done1 || busy1 || !cs1) bad++;
    end
    checks++; if (bad != 0) begin failures++; $display("FAIL abort_resume got=%0d active cycles exp=0", bad); end
    checks++; if (rx1 !== 8'h00) begin failures++; $display("FAIL abort_rx_hold got=%h exp=00", rx1); end
  endtask

  // ---------------- sequence / report ----------------
  initial begin
    loopback = 1'b1; slave_load = 8'h00; rise1 = 0;
    reset = 1'b0; start = 1'b0; start2 = 1'b0; data = 8'h00; data2 = 8'h00;
    test_reset();
    test_loopback();
    test_slave();
    test_ignore_start();
    test_back_to_back();
    test_clk_div1();
    test_reset_abort();
    checks++;
    if (exp_q.size() != 0) begin failures++; $display("FAIL scoreboard_left got=%0d exp=0", exp_q.size()); end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
